md_audio_mixer: RTL and testbench

- Parametrised, time-multiplexed stereo audio mixer for the board top; replaces the fixed two-source combinational sum of FM and PSG.
- Accepts N_CH independently-strobed sample sources, either offset-binary (FM DAC style) or two's complement (PSG style).
- Applies a per-channel gain and L/R pan, accumulates with one shared multiplier, scales and saturates.
- Presents a registered stereo sample with a valid strobe, once per mix_tick.

---
 rtl/md_audio_pkg.sv | 15 +
 rtl/md_audio_mixer_if.sv | 31 +++
 rtl/md_audio_sat.sv | 23 ++
 rtl/md_audio_mixer.sv | 129 ++++++++++++
 tb/tb_md_audio_mixer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/md_audio_pkg.sv
// md_audio_pkg: shared state type, pan bit positions and arithmetic helpers for the audio mixer
package md_audio_pkg;
    typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;
    localparam int PAN_L = 1;
    localparam int PAN_R = 0;
    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/md_audio_mixer_if.sv
// md_audio_mixer_if: channel, config and stereo output signals of the audio mixer
interface md_audio_mixer_if #(
    parameter int N_CH   = 4,
    parameter int IN_W   = 9,
    parameter int GAIN_W = 8,
    parameter int OUT_W  = 16,
    parameter int AW     = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic [N_CH*IN_W-1:0]    ch_data;
    logic [N_CH-1:0]         ch_stb;
    logic [N_CH-1:0]         ch_offset;
    logic                    cfg_we;
    logic [AW-1:0]           cfg_addr;
    logic [GAIN_W-1:0]       cfg_gain;
    logic [1:0]              cfg_pan;
    logic                    mix_tick;
    logic signed [OUT_W-1:0] out_l;
    logic signed [OUT_W-1:0] out_r;
    logic                    out_valid;
    logic [1:0]              out_clip;
    logic                    busy;
    logic                    tick_miss;
    modport master (
        output ch_data, ch_stb, ch_offset, cfg_we, cfg_addr, cfg_gain, cfg_pan, mix_tick,
        input  out_l, out_r, out_valid, out_clip, busy, tick_miss
    );
    modport slave (
        input  ch_data, ch_stb, ch_offset, cfg_we, cfg_addr, cfg_gain, cfg_pan, mix_tick,
        output out_l, out_r, out_valid, out_clip, busy, tick_miss
    );
endinterface

// File: rtl/md_audio_sat.sv
// md_audio_sat: descale an accumulator by the gain fraction, apply output shift, clamp to OUT_W
module md_audio_sat #(
    parameter int ACC_W     = 20,
    parameter int GAIN_FRAC = 6,
    parameter int OUT_SHIFT = 5,
    parameter int OUT_W     = 16
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y,
    output logic                    clip
);
    import md_audio_pkg::*;
    localparam int SW = ACC_W + OUT_SHIFT;
    logic signed [SW-1:0] v;
    logic signed [63:0]   w, s;
    always_comb begin
        v    = SW'(acc >>> GAIN_FRAC) <<< OUT_SHIFT;
        w    = 64'(v);
        s    = saturate(w, OUT_W);
        y    = s[OUT_W-1:0];
        clip = s != w;
    end
endmodule

// File: rtl/md_audio_mixer.sv
// md_audio_mixer: time-multiplexed stereo mixer with per-channel gain/pan and one shared multiplier
module md_audio_mixer #(
    parameter int N_CH      = 4,
    parameter int IN_W      = 9,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 5
) (
    input logic             MCLK,
    input logic             ext_reset,
    md_audio_mixer_if.slave bus
);
    import md_audio_pkg::*;
    localparam int AW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW    = IN_W + GAIN_W + 1;
    localparam int ACC_W = PW + $clog2(N_CH);
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

    state_t                  state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic signed [IN_W-1:0]  hold_q [N_CH], hold_d [N_CH], sh_hold_q [N_CH], sh_hold_d [N_CH];
    logic [GAIN_W-1:0]       gain_q [N_CH], gain_d [N_CH], sh_gain_q [N_CH], sh_gain_d [N_CH];
    logic [1:0]              pan_q [N_CH], pan_d [N_CH], sh_pan_q [N_CH], sh_pan_d [N_CH];
    logic signed [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [OUT_W-1:0] out_l_q, out_l_d, out_r_q, out_r_d, sat_l, sat_r;
    logic [1:0]              out_clip_q, out_clip_d;
    logic                    out_valid_q, out_valid_d, tick_miss_q, tick_miss_d, clip_l, clip_r;
    logic signed [PW-1:0]    prod;

    md_audio_sat #(.ACC_W(ACC_W), .GAIN_FRAC(GAIN_FRAC), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W))
        u_sat_l (.acc(acc_l_q), .y(sat_l), .clip(clip_l));
    md_audio_sat #(.ACC_W(ACC_W), .GAIN_FRAC(GAIN_FRAC), .OUT_SHIFT(OUT_SHIFT), .OUT_W(OUT_W))
        u_sat_r (.acc(acc_r_q), .y(sat_r), .clip(clip_r));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        sh_hold_d   = sh_hold_q;
        sh_gain_d   = sh_gain_q;
        sh_pan_d    = sh_pan_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_clip_d  = out_clip_q;
        out_valid_d = 1'b0;
        tick_miss_d = bus.mix_tick && state_q != IDLE;
        // offset-binary becomes two's complement by flipping the MSB on latch
        for (int k = 0; k < N_CH; k++) begin
            hold_d[k] = bus.ch_stb[k] ? {bus.ch_data[k*IN_W+IN_W-1] ^ bus.ch_offset[k],
                                         bus.ch_data[k*IN_W +: IN_W-1]} : hold_q[k];
            gain_d[k] = (bus.cfg_we && bus.cfg_addr == AW'(k)) ? bus.cfg_gain : gain_q[k];
            pan_d[k]  = (bus.cfg_we && bus.cfg_addr == AW'(k)) ? bus.cfg_pan : pan_q[k];
        end
        prod = PW'(sh_hold_q[idx_q]) * PW'($signed({1'b0, sh_gain_q[idx_q]}));
        case (state_q)
            IDLE: if (bus.mix_tick) begin
                state_d   = ACC;
                idx_d     = '0;
                acc_l_d   = '0;
                acc_r_d   = '0;
                sh_hold_d = hold_d;
                sh_gain_d = gain_d;
                sh_pan_d  = pan_d;
            end
            ACC: begin
                acc_l_d = sh_pan_q[idx_q][PAN_L] ? acc_l_q + ACC_W'(prod) : acc_l_q;
                acc_r_d = sh_pan_q[idx_q][PAN_R] ? acc_r_q + ACC_W'(prod) : acc_r_q;
                idx_d   = idx_q + AW'(1);
                state_d = (idx_q == AW'(N_CH - 1)) ? SCALE : ACC;
            end
            SCALE: state_d = OUT;
            OUT: begin
                out_l_d     = sat_l;
                out_r_d     = sat_r;
                out_clip_d  = {clip_l, clip_r};
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MCLK or posedge ext_reset) begin
        if (ext_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_clip_q  <= '0;
            out_valid_q <= 1'b0;
            tick_miss_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                hold_q[k]    <= '0;
                gain_q[k]    <= UNITY;
                pan_q[k]     <= 2'b11;
                sh_hold_q[k] <= '0;
                sh_gain_q[k] <= UNITY;
                sh_pan_q[k]  <= 2'b11;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_clip_q  <= out_clip_d;
            out_valid_q <= out_valid_d;
            tick_miss_q <= tick_miss_d;
            hold_q      <= hold_d;
            gain_q      <= gain_d;
            pan_q       <= pan_d;
            sh_hold_q   <= sh_hold_d;
            sh_gain_q   <= sh_gain_d;
            sh_pan_q    <= sh_pan_d;
        end
    end

    assign bus.out_l     = out_l_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_clip  = out_clip_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.tick_miss = tick_miss_q;
endmodule

// File: tb/tb_md_audio_mixer.sv
// tb_md_audio_mixer: directed and randomized checks of the mixer against a behavioural model
module tb_md_audio_mixer;
    localparam int N_CH = 4, IN_W = 9, GAIN_W = 8, GAIN_FRAC = 6, OUT_W = 16, OUT_SHIFT = 5;
    localparam int AW = 2;

    logic MCLK = 1'b0;
    logic ext_reset = 1'b1;
    int   n_checks = 0, n_fail = 0;
    bit   chk_en = 1'b0;

    int m_hold [N_CH], m_gain [N_CH], m_pan [N_CH];
    int m_cnt = 0, p_l = 0, p_r = 0, p_clip = 0, e_l = 0, e_r = 0, e_clip = 0;
    bit e_valid = 1'b0, e_miss = 1'b0;

    md_audio_mixer_if #(.N_CH(N_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus ();
    md_audio_mixer #(.N_CH(N_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC),
                     .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT))
        dut (.MCLK(MCLK), .ext_reset(ext_reset), .bus(bus));

    always #5 MCLK = ~MCLK;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int to_val(input int raw, input bit offs);
        int half = 1 << (IN_W - 1);
        if (offs) return raw - half;
        return raw >= half ? raw - 2 * half : raw;
    endfunction

    // Floor-divide by the gain unity, multiply by 2^OUT_SHIFT, clamp into OUT_W signed range
    function automatic void scale(input longint a, output int v, output bit c);
        longint unity = longint'(1) << GAIN_FRAC;
        longint lim   = longint'(1) << (OUT_W - 1);
        longint f;
        f = (a - (((a % unity) + unity) % unity)) / unity * (longint'(1) << OUT_SHIFT);
        c = f >= lim || f < -lim;
        v = f >= lim ? int'(lim - 1) : f < -lim ? int'(-lim) : int'(f);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_hold[k] = 0;
            m_gain[k] = 1 << GAIN_FRAC;
            m_pan[k]  = 3;
        end
        m_cnt = 0; e_l = 0; e_r = 0; e_clip = 0; e_valid = 0; e_miss = 0;
    endtask

    task automatic model_step();
        bit     idle, cl, cr;
        longint sl, sr;
        if (ext_reset) begin
            model_reset();
            return;
        end
        idle    = m_cnt == 0;
        e_miss  = bus.mix_tick && !idle;
        e_valid = 0;
        if (!idle) begin
            m_cnt--;
            if (m_cnt == 0) begin
                e_l = p_l; e_r = p_r; e_clip = p_clip; e_valid = 1;
            end
        end
        for (int k = 0; k < N_CH; k++)
            if (bus.ch_stb[k]) m_hold[k] = to_val(int'(bus.ch_data[k*IN_W +: IN_W]), bus.ch_offset[k]);
        if (bus.cfg_we && int'(bus.cfg_addr) < N_CH) begin
            m_gain[bus.cfg_addr] = int'(bus.cfg_gain);
            m_pan[bus.cfg_addr]  = int'(bus.cfg_pan);
        end
        if (bus.mix_tick && idle) begin
            sl = 0; sr = 0;
            for (int k = 0; k < N_CH; k++) begin
                if (m_pan[k] >= 2) sl += longint'(m_hold[k]) * m_gain[k];
                if (m_pan[k] % 2 == 1) sr += longint'(m_hold[k]) * m_gain[k];
            end
            scale(sl, p_l, cl);
            scale(sr, p_r, cr);
            p_clip = int'(cl) * 2 + int'(cr);
            m_cnt  = N_CH + 2;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge MCLK or posedge ext_reset);
            model_step();
        end
    end

    initial forever begin
        @(negedge MCLK);
        if (chk_en) begin
            check("out_valid", int'(bus.out_valid), int'(e_valid));
            check("busy", int'(bus.busy), int'(m_cnt > 0));
            check("tick_miss", int'(bus.tick_miss), int'(e_miss));
            check("out_l", int'($signed(bus.out_l)), e_l);
            check("out_r", int'($signed(bus.out_r)), e_r);
            check("out_clip", int'(bus.out_clip), e_clip);
        end
    end

    task automatic cfg(input int ch, input int g, input int p);
        @(negedge MCLK);
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(ch); bus.cfg_gain = GAIN_W'(g); bus.cfg_pan = 2'(p);
        @(negedge MCLK);
        bus.cfg_we = 1'b0;
    endtask

    task automatic stb(input int ch, input int v);
        @(negedge MCLK);
        bus.ch_data[ch*IN_W +: IN_W] = IN_W'(v);
        bus.ch_stb[ch] = 1'b1;
        @(negedge MCLK);
        bus.ch_stb = '0;
    endtask

    task automatic stb_all(input int v);
        @(negedge MCLK);
        for (int k = 0; k < N_CH; k++) bus.ch_data[k*IN_W +: IN_W] = IN_W'(v);
        bus.ch_stb = '1;
        @(negedge MCLK);
        bus.ch_stb = '0;
    endtask

    task automatic wait_check(input string nm, input int l, input int r, input int c);
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge MCLK);
        check({nm, "_seen"}, int'(bus.out_valid), 1);
        check({nm, "_l"}, int'($signed(bus.out_l)), l);
        check({nm, "_r"}, int'($signed(bus.out_r)), r);
        check({nm, "_clip"}, int'(bus.out_clip), c);
    endtask

    task automatic pass(input string nm, input int l, input int r, input int c);
        @(negedge MCLK);
        bus.mix_tick = 1'b1;
        @(negedge MCLK);
        bus.mix_tick = 1'b0;
        wait_check(nm, l, r, c);
    endtask

    initial begin
        int n_val, n_miss;
        bus.ch_data = '0; bus.ch_stb = '0; bus.ch_offset = '0; bus.cfg_we = 1'b0;
        bus.cfg_addr = '0; bus.cfg_gain = '0; bus.cfg_pan = '0; bus.mix_tick = 1'b0;
        repeat (3) @(posedge MCLK);
        #2 ext_reset = 1'b0;
        @(negedge MCLK);
        check("rst_out_l", int'($signed(bus.out_l)), 0);
        check("rst_out_r", int'($signed(bus.out_r)), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_clip", int'(bus.out_clip), 0);
        chk_en = 1'b1;

        bus.ch_offset = 4'b0001;
        stb(0, 'h1FF);
        pass("offset", 'h1FE0, 'h1FE0, 0);

        bus.ch_offset = 4'b0000;
        for (int k = 0; k < N_CH; k++) cfg(k, 'hFF, 3);
        stb_all('h0FF);
        pass("sat_pos", 32767, 32767, 3);
        stb_all('h100);
        pass("sat_neg", -32768, -32768, 3);

        for (int k = 0; k < N_CH; k++) cfg(k, 'h40, 3);
        stb_all(0);
        cfg(1, 'h40, 1);
        stb(1, 100);
        pass("pan_r", 0, 3200, 0);

        cfg(1, 'h40, 3);
        stb(1, 0);
        cfg(2, 'h20, 3);
        stb(2, 'h1C0);
        pass("gain_half", -1024, -1024, 0);
        stb(2, 'h1FF);
        pass("floor", -32, -32, 0);
        stb(2, 0);

        n_val = 0; n_miss = 0;
        @(negedge MCLK); bus.mix_tick = 1'b1;
        @(negedge MCLK); bus.mix_tick = 1'b0;
        @(negedge MCLK); bus.mix_tick = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge MCLK);
            bus.mix_tick = 1'b0;
            n_val  += int'(bus.out_valid);
            n_miss += int'(bus.tick_miss);
        end
        check("dbl_valids", n_val, 1);
        check("dbl_misses", n_miss, 1);

        @(negedge MCLK);
        bus.ch_data[0 +: IN_W] = IN_W'(50); bus.ch_stb[0] = 1'b1; bus.mix_tick = 1'b1;
        @(negedge MCLK);
        bus.ch_stb = '0; bus.mix_tick = 1'b0;
        wait_check("stb_bypass", 1600, 1600, 0);

        @(negedge MCLK);
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_gain = 8'h80; bus.cfg_pan = 2'b10; bus.mix_tick = 1'b1;
        @(negedge MCLK);
        bus.cfg_we = 1'b0; bus.mix_tick = 1'b0;
        wait_check("cfg_bypass", 3200, 0, 0);

        stb(0, 10);
        @(negedge MCLK); bus.mix_tick = 1'b1;
        @(negedge MCLK); bus.mix_tick = 1'b0;
        repeat (3) @(posedge MCLK);
        #2 ext_reset = 1'b1;
        @(posedge MCLK);
        #2 ext_reset = 1'b0;
        n_val = 0;
        repeat (10) begin
            @(negedge MCLK);
            n_val += int'(bus.out_valid);
        end
        check("abort_no_valid", n_val, 0);
        check("abort_out_l", int'($signed(bus.out_l)), 0);
        check("abort_busy", int'(bus.busy), 0);
        stb(0, 10);
        pass("post_rst_unity", 320, 320, 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge MCLK);
            if (i % 500 == 0) bus.ch_offset = N_CH'($urandom);
            for (int k = 0; k < N_CH; k++) bus.ch_stb[k] = $urandom_range(0, 3) == 0;
            bus.ch_data  = (N_CH*IN_W)'({$urandom, $urandom});
            bus.cfg_we   = $urandom_range(0, 7) == 0;
            bus.cfg_addr = AW'($urandom);
            bus.cfg_gain = GAIN_W'($urandom);
            bus.cfg_pan  = 2'($urandom);
            bus.mix_tick = $urandom_range(0, 5) == 0;
        end
        @(negedge MCLK);
        bus.ch_stb = '0; bus.cfg_we = 1'b0; bus.mix_tick = 1'b0;
        repeat (20) @(negedge MCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
